wave_sweep_controller: RTL and testbench

WAVE_SWEEP_CONTROLLER -- requirements
Module: wave_sweep_controller

---
 rtl/wave_sweep_controller.sv | 220 ++++++++++++++++++++++
 tb/tb_wave_sweep_controller.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wave_sweep_controller.sv
// Phase-sweep sequencer: programs amplitude, steps phase after each dwell, optional restart.
// Define WAVE_SWEEP_BIDIR_EN to ramp back down to phase_start after the up-ramp.
module wave_sweep_controller (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic       abort_i,
  input  logic       continuous_i,
  input  logic [7:0] amplitude_i,
  input  logic [1:0] waveform_i,
  input  logic [7:0] phase_start_i,
  input  logic [7:0] phase_stop_i,
  input  logic [7:0] phase_step_i,
  input  logic [7:0] dwell_i,
  input  logic       sample_strobe_i,
  output logic       gen_enable_o,
  output logic [1:0] gen_waveform_o,
  output logic       gen_set_phase_strobe_o,
  output logic       gen_set_amplitude_strobe_o,
  output logic [7:0] gen_data_o,
  output logic       busy_o,
  output logic       done_o,
  output logic [7:0] cur_phase_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_AMP,
    S_LOAD_PHASE,
    S_RUN,
    S_DONE
  } state_t;

  state_t     state, state_n;
  logic [7:0] cur_phase, phase_n;
  logic [7:0] dwell_cnt, cnt_n;
  logic [7:0] amp_q, amp_n;
  logic [1:0] wave_q, wave_n;
  logic [7:0] start_q, start_n;
  logic [7:0] stop_q, stop_n;
  logic [7:0] step_q, step_n;
  logic [7:0] dwell_q, dwell_n;
  logic       cont_q, cont_n;
`ifdef WAVE_SWEEP_BIDIR_EN
  logic       dir_q, dir_n;
  logic [8:0] dn_diff;
  logic       dn_ok;
`endif

  logic       enable_n;
  logic [1:0] gen_wave_n;
  logic       ph_stb_n;
  logic       amp_stb_n;
  logic [7:0] data_n;
  logic       busy_n;
  logic       done_n;

  logic [8:0] up_sum;
  logic       up_ok;
  logic       dwell_hit;
  logic       sweep_end;

  // Step and dwell are stored already forced to a minimum of 1, so the datapath never sees zero.
  assign up_sum    = {1'b0, cur_phase} + {1'b0, step_q};
  assign up_ok     = !up_sum[8] && (up_sum[7:0] <= stop_q);
  assign dwell_hit = ({1'b0, dwell_cnt} + 9'd1) >= {1'b0, dwell_q};
`ifdef WAVE_SWEEP_BIDIR_EN
  assign dn_diff   = {1'b0, cur_phase} - {1'b0, step_q};
  assign dn_ok     = !dn_diff[8] && (dn_diff[7:0] >= start_q);
`endif

  assign cur_phase_o = cur_phase;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state                      <= S_IDLE;
      cur_phase                  <= '0;
      dwell_cnt                  <= '0;
      amp_q                      <= '0;
      wave_q                     <= '0;
      start_q                    <= '0;
      stop_q                     <= '0;
      step_q                     <= '0;
      dwell_q                    <= '0;
      cont_q                     <= 1'b0;
`ifdef WAVE_SWEEP_BIDIR_EN
      dir_q                      <= 1'b0;
`endif
      gen_enable_o               <= 1'b0;
      gen_waveform_o             <= '0;
      gen_set_phase_strobe_o     <= 1'b0;
      gen_set_amplitude_strobe_o <= 1'b0;
      gen_data_o                 <= '0;
      busy_o                     <= 1'b0;
      done_o                     <= 1'b0;
    end else begin
      state                      <= state_n;
      cur_phase                  <= phase_n;
      dwell_cnt                  <= cnt_n;
      amp_q                      <= amp_n;
      wave_q                     <= wave_n;
      start_q                    <= start_n;
      stop_q                     <= stop_n;
      step_q                     <= step_n;
      dwell_q                    <= dwell_n;
      cont_q                     <= cont_n;
`ifdef WAVE_SWEEP_BIDIR_EN
      dir_q                      <= dir_n;
`endif
      gen_enable_o               <= enable_n;
      gen_waveform_o             <= gen_wave_n;
      gen_set_phase_strobe_o     <= ph_stb_n;
      gen_set_amplitude_strobe_o <= amp_stb_n;
      gen_data_o                 <= data_n;
      busy_o                     <= busy_n;
      done_o                     <= done_n;
    end
  end

  always_comb begin
    state_n   = state;
    phase_n   = cur_phase;
    cnt_n     = dwell_cnt;
    amp_n     = amp_q;
    wave_n    = wave_q;
    start_n   = start_q;
    stop_n    = stop_q;
    step_n    = step_q;
    dwell_n   = dwell_q;
    cont_n    = cont_q;
    sweep_end = 1'b0;
`ifdef WAVE_SWEEP_BIDIR_EN
    dir_n     = dir_q;
`endif

    if (abort_i) begin
      state_n = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_i) begin
            amp_n   = amplitude_i;
            wave_n  = waveform_i;
            start_n = phase_start_i;
            stop_n  = phase_stop_i;
            step_n  = (phase_step_i == 8'd0) ? 8'd1 : phase_step_i;
            dwell_n = (dwell_i == 8'd0) ? 8'd1 : dwell_i;
            cont_n  = continuous_i;
            phase_n = phase_start_i;
            cnt_n   = '0;
`ifdef WAVE_SWEEP_BIDIR_EN
            dir_n   = 1'b0;
`endif
            state_n = S_LOAD_AMP;
          end
        end
        S_LOAD_AMP: state_n = S_LOAD_PHASE;
        S_LOAD_PHASE: begin
          cnt_n   = '0;
          state_n = S_RUN;
        end
        S_RUN: begin
          if (sample_strobe_i) begin
            if (dwell_hit) begin
              cnt_n   = '0;
              state_n = S_LOAD_PHASE;
`ifdef WAVE_SWEEP_BIDIR_EN
              // Going up until the ramp overshoots, then turning round on the same edge.
              if (!dir_q && up_ok) begin
                phase_n = up_sum[7:0];
              end else if (dn_ok) begin
                phase_n = dn_diff[7:0];
                dir_n   = 1'b1;
              end else begin
                sweep_end = 1'b1;
              end
`else
              if (up_ok) begin
                phase_n = up_sum[7:0];
              end else begin
                sweep_end = 1'b1;
              end
`endif
              if (sweep_end) begin
                if (cont_q) begin
                  phase_n = start_q;
`ifdef WAVE_SWEEP_BIDIR_EN
                  dir_n   = 1'b0;
`endif
                end else begin
                  state_n = S_DONE;
                end
              end
            end else begin
              cnt_n = dwell_cnt + 8'd1;
            end
          end
        end
        S_DONE:  state_n = S_IDLE;
        default: state_n = S_IDLE;
      endcase
    end

    // Outputs are decoded from the state being entered so they line up with it after the edge.
    busy_n     = (state_n != S_IDLE);
    done_n     = (state_n == S_DONE);
    amp_stb_n  = (state_n == S_LOAD_AMP);
    ph_stb_n   = (state_n == S_LOAD_PHASE);
    enable_n   = (state_n == S_RUN) || ((state_n == S_LOAD_PHASE) && (state == S_RUN));
    gen_wave_n = busy_n ? wave_n : 2'd0;
    if (amp_stb_n) begin
      data_n = amp_n;
    end else if (ph_stb_n) begin
      data_n = phase_n;
    end else begin
      data_n = 8'd0;
    end
  end

endmodule

// File: tb/tb_wave_sweep_controller.sv
// Testbench for wave_sweep_controller: directed and random sweeps checked against a phase-list model.
// Honours WAVE_SWEEP_BIDIR_EN to expect the down-ramp as well.
module tb_wave_sweep_controller;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       start_i;
  logic       abort_i;
  logic       continuous_i;
  logic [7:0] amplitude_i;
  logic [1:0] waveform_i;
  logic [7:0] phase_start_i;
  logic [7:0] phase_stop_i;
  logic [7:0] phase_step_i;
  logic [7:0] dwell_i;
  logic       sample_strobe_i;
  logic       gen_enable_o;
  logic [1:0] gen_waveform_o;
  logic       gen_set_phase_strobe_o;
  logic       gen_set_amplitude_strobe_o;
  logic [7:0] gen_data_o;
  logic       busy_o;
  logic       done_o;
  logic [7:0] cur_phase_o;

  int n_checked = 0;
  int n_failed  = 0;
  int exp_seq[$];

`ifdef WAVE_SWEEP_BIDIR_EN
  localparam bit BIDIR = 1'b1;
`else
  localparam bit BIDIR = 1'b0;
`endif

  wave_sweep_controller dut (
    .clk_i                      (clk_i),
    .rst_i                      (rst_i),
    .start_i                    (start_i),
    .abort_i                    (abort_i),
    .continuous_i               (continuous_i),
    .amplitude_i                (amplitude_i),
    .waveform_i                 (waveform_i),
    .phase_start_i              (phase_start_i),
    .phase_stop_i               (phase_stop_i),
    .phase_step_i               (phase_step_i),
    .dwell_i                    (dwell_i),
    .sample_strobe_i            (sample_strobe_i),
    .gen_enable_o               (gen_enable_o),
    .gen_waveform_o             (gen_waveform_o),
    .gen_set_phase_strobe_o     (gen_set_phase_strobe_o),
    .gen_set_amplitude_strobe_o (gen_set_amplitude_strobe_o),
    .gen_data_o                 (gen_data_o),
    .busy_o                     (busy_o),
    .done_o                     (done_o),
    .cur_phase_o                (cur_phase_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    n_checked++;
    assert (obs === exp) else begin
      n_failed++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected phase list for one pass, built from plain integer arithmetic.
  task automatic build_seq(input int ps, input int pe, input int st);
    int p;
    int s;
    s = (st == 0) ? 1 : st;
    exp_seq.delete();
    p = ps;
    exp_seq.push_back(p);
    while (p + s <= pe) begin
      p = p + s;
      exp_seq.push_back(p);
    end
    if (BIDIR) begin
      while (p - s >= ps) begin
        p = p - s;
        exp_seq.push_back(p);
      end
    end
  endtask

  task automatic scramble_cfg();
    amplitude_i   = 8'($urandom);
    waveform_i    = 2'($urandom);
    phase_start_i = 8'($urandom);
    phase_stop_i  = 8'($urandom);
    phase_step_i  = 8'($urandom);
    dwell_i       = 8'($urandom);
  endtask

  task automatic apply_stimulus(input logic [7:0] ps, input logic [7:0] pe, input logic [7:0] st,
                                input logic [7:0] dw, input logic [7:0] amp, input logic [1:0] wv,
                                input bit cont);
    phase_start_i = ps;
    phase_stop_i  = pe;
    phase_step_i  = st;
    dwell_i       = dw;
    amplitude_i   = amp;
    waveform_i    = wv;
    continuous_i  = cont;
    start_i       = 1'b1;
  endtask

  task automatic check_idle(input string tag);
    check_output({tag, "_busy"}, busy_o, 0);
    check_output({tag, "_en"}, gen_enable_o, 0);
    check_output({tag, "_wave"}, gen_waveform_o, 0);
    check_output({tag, "_done"}, done_o, 0);
    check_output({tag, "_pstb"}, gen_set_phase_strobe_o, 0);
  endtask

  // Starts a sweep and follows it phase by phase; in continuous mode it stops after steps_cont steps.
  task automatic run_sweep(input string tag, input logic [7:0] ps, input logic [7:0] pe,
                           input logic [7:0] st, input logic [7:0] dw, input logic [7:0] amp,
                           input logic [1:0] wv, input bit cont, input int gap, input int steps_cont);
    int len;
    int eff_d;
    int n_steps;
    int cnt;
    int iter;
    bit s;
    build_seq(ps, pe, st);
    len   = exp_seq.size();
    eff_d = (dw == 0) ? 1 : dw;
    apply_stimulus(ps, pe, st, dw, amp, wv, cont);
    tick();
    start_i = 1'b0;
    scramble_cfg();
    sample_strobe_i = 1'($urandom);
    check_output({tag, "_amp_stb"}, gen_set_amplitude_strobe_o, 1);
    check_output({tag, "_amp_phstb"}, gen_set_phase_strobe_o, 0);
    check_output({tag, "_amp_data"}, gen_data_o, amp);
    check_output({tag, "_amp_en"}, gen_enable_o, 0);
    check_output({tag, "_amp_busy"}, busy_o, 1);
    check_output({tag, "_amp_wave"}, gen_waveform_o, wv);
    tick();
    check_output({tag, "_ph0_stb"}, gen_set_phase_strobe_o, 1);
    check_output({tag, "_ph0_ampstb"}, gen_set_amplitude_strobe_o, 0);
    check_output({tag, "_ph0_data"}, gen_data_o, 9'(exp_seq[0]));
    n_steps = cont ? steps_cont : len;
    for (int i = 0; i < n_steps; i++) begin
      sample_strobe_i = 1'($urandom);
      scramble_cfg();
      tick();
      check_output({tag, "_run_en"}, gen_enable_o, 1);
      check_output({tag, "_run_pstb"}, gen_set_phase_strobe_o, 0);
      check_output({tag, "_run_data"}, gen_data_o, 0);
      check_output({tag, "_run_phase"}, cur_phase_o, 9'(exp_seq[i % len]));
      check_output({tag, "_run_wave"}, gen_waveform_o, wv);
      cnt  = 0;
      iter = 0;
      while (cnt < eff_d) begin
        if (gap > 0) s = ((iter % gap) == gap - 1);
        else         s = (($urandom % 3) != 0) || (iter > 20);
        sample_strobe_i = s;
        scramble_cfg();
        tick();
        iter++;
        if (s) cnt++;
        if (cnt < eff_d) check_output({tag, "_dwell_hold"}, gen_set_phase_strobe_o, 0);
      end
      sample_strobe_i = 1'b0;
      if (cont || (i + 1 < len)) begin
        check_output({tag, "_step_stb"}, gen_set_phase_strobe_o, 1);
        check_output({tag, "_step_data"}, gen_data_o, 9'(exp_seq[(i + 1) % len]));
        check_output({tag, "_step_en"}, gen_enable_o, 1);
        check_output({tag, "_step_done"}, done_o, 0);
      end else begin
        check_output({tag, "_done"}, done_o, 1);
        check_output({tag, "_done_busy"}, busy_o, 1);
        check_output({tag, "_done_en"}, gen_enable_o, 0);
        check_output({tag, "_done_pstb"}, gen_set_phase_strobe_o, 0);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        check_idle({tag, "_after_done"});
        check_output({tag, "_after_done_ampstb"}, gen_set_amplitude_strobe_o, 0);
      end
    end
  endtask

  task automatic abort_sweep(input string tag);
    abort_i = 1'b1;
    start_i = 1'b1;
    sample_strobe_i = 1'b1;
    tick();
    abort_i = 1'b0;
    start_i = 1'b0;
    sample_strobe_i = 1'b0;
    check_idle({tag, "_abort"});
    tick();
    check_idle({tag, "_abort_next"});
  endtask

  initial begin
    rst_i = 1'b0;
    start_i = 1'b0;
    abort_i = 1'b0;
    continuous_i = 1'b0;
    sample_strobe_i = 1'b0;
    scramble_cfg();
    tick();
    tick();
    check_idle("reset");
    check_output("reset_phase", cur_phase_o, 0);
    check_output("reset_data", gen_data_o, 0);
    check_output("reset_ampstb", gen_set_amplitude_strobe_o, 0);
    rst_i = 1'b1;
    tick();
    check_idle("post_reset");

    run_sweep("basic", 8'd10, 8'd40, 8'd10, 8'd2, 8'h5A, 2'd2, 1'b0, 4, 0);
    run_sweep("carry", 8'd250, 8'd255, 8'd10, 8'd1, 8'hC3, 2'd1, 1'b0, 0, 0);
    run_sweep("cont", 8'd0, 8'd2, 8'd1, 8'd1, 8'h11, 2'd3, 1'b1, 0, 7);
    abort_sweep("cont");
    run_sweep("zero_cfg", 8'd5, 8'd8, 8'd0, 8'd0, 8'h77, 2'd1, 1'b0, 0, 0);
    run_sweep("inverted", 8'd100, 8'd50, 8'd3, 8'd2, 8'h20, 2'd2, 1'b0, 0, 0);
    run_sweep("ramp20", 8'd0, 8'd20, 8'd10, 8'd1, 8'h44, 2'd3, 1'b0, 0, 0);

    // Abort and start together while idle must stay idle.
    abort_sweep("idle");

    // Reset mid-run, then start on the very first edge after release.
    apply_stimulus(8'd30, 8'd90, 8'd5, 8'd3, 8'h66, 2'd2, 1'b0);
    tick();
    start_i = 1'b0;
    tick();
    tick();
    check_output("pre_reset_en", gen_enable_o, 1);
    rst_i = 1'b0;
    tick();
    check_idle("mid_reset");
    check_output("mid_reset_phase", cur_phase_o, 0);
    check_output("mid_reset_data", gen_data_o, 0);
    rst_i = 1'b1;
    apply_stimulus(8'd7, 8'd9, 8'd1, 8'd1, 8'h99, 2'd1, 1'b0);
    tick();
    start_i = 1'b0;
    check_output("restart_ampstb", gen_set_amplitude_strobe_o, 1);
    check_output("restart_data", gen_data_o, 8'h99);
    abort_sweep("restart");

    for (int r = 0; r < 10; r++) begin
      logic [7:0] ps;
      logic [7:0] pe;
      int         top;
      ps  = 8'($urandom);
      top = int'(ps) + int'($urandom_range(0, 40));
      pe  = (top > 255) ? 8'd255 : 8'(top);
      if (($urandom % 5) == 0) pe = 8'($urandom);
      if (($urandom % 4) == 0) begin
        run_sweep("rand_cont", ps, pe, 8'($urandom_range(0, 20)), 8'($urandom_range(0, 3)),
                  8'($urandom), 2'($urandom), 1'b1, 0, int'($urandom_range(1, 12)));
        abort_sweep("rand_cont");
      end else begin
        run_sweep("rand", ps, pe, 8'($urandom_range(0, 20)), 8'($urandom_range(0, 3)),
                  8'($urandom), 2'($urandom), 1'b0, 0, 0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checked, n_failed);
    $finish;
  end

endmodule
